uart_rx_frame: RTL and testbench
================================

# uart_rx_frame

Oversampling UART frame receiver: the receive end of the team's UART transmitter, decoding the same frame format (configurable start/data/stop bit counts, LSB-first data, OVERSAMPLE-rate clock enable) back into parallel bytes. Sits between the board RX pin and the Forth CPU I/O port, and presents each received word through a valid/ready handshake with frame-error and overrun flags.

## Interface
- START, 1: start bits per frame (≥1)
- DATA, 8: data bits per frame (1..16)
- STOP, 2: stop bits per frame (≥1)
- OSR, 16: samples per bit; any integer ≥4, power of two NOT required
- START_LEVEL, 1: line level of a start bit; idle level is ~START_LEVEL
- STOP_LEVEL, 1: required line level of every stop bit

Ports:
- i_divided_clk  in  1  OSR-rate clock
- i_rst_n  in  1  asynchronous active-low reset
- i_en  in  1  sample enable; all state advances only on cycles with i_en=1 (the 2-flop synchronizer runs every clock)
- i_rx  in  1  asynchronous serial line
- i_ready  in  1  consumer accepts o_data when o_valid=1
- o_data  out  DATA  received word, LSB = first data bit
- o_valid  out  1  o_data holds an unconsumed word
- o_frame_err  out  1  word in o_data had ≥1 bad stop bit; valid only with o_valid
- o_overrun  out  1  sticky; a frame completed while o_valid=1; cleared by reset only
- d_state  out  3  debug: current state encoding

## Operation
- States: REARM=0, IDLE=1, START=2, DATA=3, STOP=4.
- Reset: state REARM; o_data=0, o_valid=0, o_frame_err=0, o_overrun=0; sample and bit counters 0; synchronizer flops = idle level.
- rx_s = synchronized line; maj = majority of the three most recent enabled-cycle samples of rx_s.
- REARM: on an enabled cycle with rx_s = idle level → IDLE. Prevents triggering on a trailing stop bit whose level equals START_LEVEL.
- IDLE: on an enabled cycle with rx_s = START_LEVEL → START, sample counter=0, bit counter=0. This is frame cycle 0.
- Bit k (start bits first, then data, then stop) occupies frame cycles k·OSR .. k·OSR+OSR−1; decision sample = maj at in-bit count OSR/2 (integer division).
- START: if any start-bit decision ≠ START_LEVEL → false start, go to IDLE; no output and no flag change. After START bits → DATA.
- DATA: each decision shifted in LSB-first. After DATA bits → STOP.
- STOP: any decision ≠ STOP_LEVEL sets a frame-error latch. At the end of the last stop bit (frame cycle (START+DATA+STOP)·OSR−1) deliver the word and go to REARM.
- Delivery: if o_valid=0 or i_ready=1 in the same cycle → load o_data, o_frame_err, set o_valid. Otherwise discard the word and set o_overrun.
- Handshake: o_valid falls the cycle after i_ready=1 is sampled with o_valid=1, unless a delivery occurs in that same cycle (then o_valid stays 1 with the new word). o_data is stable while o_valid=1.
- i_en=0 freezes all counters, the sample history and the state. The handshake still operates.
- Counter widths: sample counter $clog2(OSR); bit counter $clog2(START+DATA+STOP+1). No counter wraps within a frame.
- Reset asserted mid-frame: all of the above reset values apply immediately. The partial word is lost and no flag is set.

## Timing
- i_rx to rx_s: 2 clocks.
- o_valid registered high on the clock edge ending frame cycle (START+DATA+STOP)·OSR−1. Defaults: cycle 175.
- Earliest next start accepted: one enabled cycle after REARM sees idle level.
- Throughput: one word per frame, with no dead time beyond REARM.

## Structure
- Shared package uart_pkg: state encodings, default START/DATA/STOP/OSR, level constants. The transmitter imports the same package.
- Sub-module uart_rx_filter: 2-flop synchronizer plus 3-sample majority history, gated by i_en.
- Everything else is in one FSM module.

## Test plan
All scenarios use defaults, with i_en toggling 1/0/1 pattern unless stated.
- Frame 0xA5, stop bits 1,1, i_ready=0 → o_data=0xA5, o_valid=1 at frame cycle 175, o_frame_err=0.
- 3-enabled-cycle START_LEVEL glitch in IDLE → state returns to IDLE, o_valid stays 0.
- Frame 0x3C with second stop bit at idle level → o_data=0x3C, o_frame_err=1.
- Two frames 0x11, 0x22 back-to-back, i_ready=0 throughout → o_data=0x11, o_overrun=1. Then i_ready=1 → o_valid drops next cycle.
- OSR=12, frame 0x5A transmitted by the team transmitter with OSR=12 → o_data=0x5A, no errors.
- i_rst_n low at frame cycle 80 of a 0xFF frame → all outputs 0 immediately. After release, a following 0x01 frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults, line levels, state encodings and the
// majority-vote helper used by both receive and transmit ends.
package uart_pkg;

  localparam int unsigned START_BITS_DEF  = 1;
  localparam int unsigned DATA_BITS_DEF   = 8;
  localparam int unsigned STOP_BITS_DEF   = 2;
  localparam int unsigned OSR_DEF         = 16;

  localparam logic        START_LEVEL_DEF = 1'b0;
  localparam logic        STOP_LEVEL_DEF  = 1'b1;

  localparam logic [2:0]  ST_REARM        = 3'd0;
  localparam logic [2:0]  ST_IDLE         = 3'd1;
  localparam logic [2:0]  ST_START        = 3'd2;
  localparam logic [2:0]  ST_DATA         = 3'd3;
  localparam logic [2:0]  ST_STOP         = 3'd4;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Word handshake between the UART receiver and its consumer; signal names are
// seen from the receiver side.
interface uart_rx_frame_if #(
  parameter int unsigned DATA = uart_pkg::DATA_BITS_DEF
);
  logic [DATA-1:0] o_data;
  logic            o_valid;
  logic            o_frame_err;
  logic            o_overrun;
  logic            i_ready;

  modport master (output o_data, o_valid, o_frame_err, o_overrun, input i_ready);
  modport slave  (input o_data, o_valid, o_frame_err, o_overrun, output i_ready);
endinterface

// File: rtl/uart_rx_filter.sv
// RX line conditioning: 2-flop synchronizer (free running) plus a majority vote
// over the current and two previous enabled-cycle samples.
module uart_rx_filter
  import uart_pkg::*;
#(
  parameter logic IDLE_LEVEL = ~START_LEVEL_DEF
) (
  input  logic i_divided_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_maj
);

  logic       sync1_q;
  logic       sync2_q;
  logic [1:0] hist_q;

  always_ff @(posedge i_divided_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= IDLE_LEVEL;
      sync2_q <= IDLE_LEVEL;
      hist_q  <= {2{IDLE_LEVEL}};
    end else begin
      sync1_q <= i_rx;
      sync2_q <= sync1_q;
      if (i_en) hist_q <= {hist_q[0], sync2_q};
    end
  end

  assign o_rx_s = sync2_q;
  assign o_maj  = maj3({hist_q, sync2_q});

endmodule

// File: rtl/uart_rx_frame.sv
// Oversampling UART frame receiver: decodes start/data/stop bits with mid-bit
// majority decisions and hands each word over a valid/ready interface.
//
// state  | meaning
// REARM  | frame just ended, wait for idle line before accepting a start
// IDLE   | line idle, waiting for a start-level sample
// START  | inside start bits, a wrong mid-bit decision aborts as false start
// DATA   | shifting in data bits LSB-first
// STOP   | checking stop bits, delivering the word at the last sample
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned START       = START_BITS_DEF,
  parameter int unsigned DATA        = DATA_BITS_DEF,
  parameter int unsigned STOP        = STOP_BITS_DEF,
  parameter int unsigned OSR         = OSR_DEF,
  parameter logic        START_LEVEL = START_LEVEL_DEF,
  parameter logic        STOP_LEVEL  = STOP_LEVEL_DEF
) (
  input  logic            i_divided_clk,
  input  logic            i_rst_n,
  input  logic            i_en,
  input  logic            i_rx,
  uart_rx_frame_if.master rx_if,
  output logic [2:0]      d_state
);

  localparam int unsigned TOTAL = START + DATA + STOP;
  localparam int unsigned SW    = $clog2(OSR);
  localparam int unsigned BW    = $clog2(TOTAL + 1);
  localparam logic        IDLE_LEVEL    = ~START_LEVEL;
  localparam logic [SW-1:0] SAMP_MID    = SW'(OSR / 2);
  localparam logic [SW-1:0] SAMP_LAST   = SW'(OSR - 1);
  localparam logic [BW-1:0] BIT_START_END = BW'(START - 1);
  localparam logic [BW-1:0] BIT_DATA_END  = BW'(START + DATA - 1);
  localparam logic [BW-1:0] BIT_LAST      = BW'(TOTAL - 1);

  logic            rx_s, maj;
  logic [2:0]      state_q, state_d;
  logic [SW-1:0]   samp_q, samp_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DATA-1:0] shift_q, shift_d;
  logic            fe_latch_q, fe_latch_d;
  logic            deliver;
  logic [DATA-1:0] data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;

  uart_rx_filter #(.IDLE_LEVEL(IDLE_LEVEL)) u_filter (
    .i_divided_clk (i_divided_clk),
    .i_rst_n       (i_rst_n),
    .i_en          (i_en),
    .i_rx          (i_rx),
    .o_rx_s        (rx_s),
    .o_maj         (maj)
  );

  // samp_q/bit_q always hold the position of the frame cycle being processed;
  // the start-detect cycle in IDLE is frame cycle 0, so START begins at sample 1.
  always_comb begin
    state_d    = state_q;
    samp_d     = samp_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    fe_latch_d = fe_latch_q;
    deliver    = 1'b0;
    if (i_en) begin
      case (state_q)
        ST_REARM: if (rx_s == IDLE_LEVEL) state_d = ST_IDLE;
        ST_IDLE: begin
          fe_latch_d = 1'b0;
          if (rx_s == START_LEVEL) begin
            state_d = ST_START;
            samp_d  = SW'(1);
          end
        end
        ST_START, ST_DATA, ST_STOP: begin
          if (samp_q == SAMP_LAST) begin
            samp_d = '0;
            bit_d  = bit_q + 1'b1;
          end else begin
            samp_d = samp_q + 1'b1;
          end
          if (samp_q == SAMP_MID) begin
            if (state_q == ST_START && maj != START_LEVEL) begin
              state_d = ST_IDLE;
              samp_d  = '0;
              bit_d   = '0;
            end
            if (state_q == ST_DATA) shift_d = (shift_q >> 1) | (DATA'(maj) << (DATA - 1));
            if (state_q == ST_STOP && maj != STOP_LEVEL) fe_latch_d = 1'b1;
          end
          if (samp_q == SAMP_LAST) begin
            if (state_q == ST_START && bit_q == BIT_START_END) state_d = ST_DATA;
            if (state_q == ST_DATA && bit_q == BIT_DATA_END) state_d = ST_STOP;
            if (state_q == ST_STOP && bit_q == BIT_LAST) begin
              deliver = 1'b1;
              state_d = ST_REARM;
              samp_d  = '0;
              bit_d   = '0;
            end
          end
        end
        default: state_d = ST_REARM;
      endcase
    end
  end

  // A delivery in the same cycle as a consume replaces the word without a gap.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    if (valid_q && rx_if.i_ready) valid_d = 1'b0;
    if (deliver) begin
      if (!valid_q || rx_if.i_ready) begin
        data_d  = shift_q;
        ferr_d  = fe_latch_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_divided_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_REARM;
      samp_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      fe_latch_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      samp_q     <= samp_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      fe_latch_q <= fe_latch_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_if.o_data      = data_q;
  assign rx_if.o_valid     = valid_q;
  assign rx_if.o_frame_err = ferr_q;
  assign rx_if.o_overrun   = ovr_q;
  assign d_state           = state_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: frames built bit-by-bit from the frame format and
// compared against a word-level delivery/overrun model.
module tb_uart_rx_frame;
  import uart_pkg::*;

  localparam int NB = START_BITS_DEF + DATA_BITS_DEF + STOP_BITS_DEF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       rx16 = 1'b1;
  logic       rx12 = 1'b1;
  logic [2:0] st16, st12;

  uart_rx_frame_if if16 ();
  uart_rx_frame_if if12 ();

  uart_rx_frame #(.OSR(16)) dut (
    .i_divided_clk (clk),
    .i_rst_n       (rst_n),
    .i_en          (en),
    .i_rx          (rx16),
    .rx_if         (if16),
    .d_state       (st16)
  );

  uart_rx_frame #(.OSR(12)) dut12 (
    .i_divided_clk (clk),
    .i_rst_n       (rst_n),
    .i_en          (en),
    .i_rx          (rx12),
    .rx_if         (if12),
    .d_state       (st12)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   nedge = 0;
  int   rise_edge = -1;
  int   start_edge = 0;
  logic en_phase = 1'b1;
  logic use12 = 1'b0;
  logic prev_valid = 1'b0;

  // word-level reference model of the OSR=16 receiver output
  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_ferr = 1'b0;
  logic       m_ovr = 1'b0;

  always @(negedge clk) begin
    if (if16.o_valid && !prev_valid) rise_edge = nedge;
    prev_valid = if16.o_valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    en = en_phase;
    en_phase = ~en_phase;
    @(posedge clk);
    #1;
    nedge++;
  endtask

  task automatic drive(input logic v);
    if (use12) rx12 = v;
    else rx16 = v;
  endtask

  task automatic hold_idle(input int n_en);
    drive(1'b1);
    for (int i = 0; i < n_en; i++) begin
      tick();
      tick();
    end
  endtask

  // Returns early (with reset asserted) when abort_at enabled cycles have been sent.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] stop_bad, input int osr,
                            input int abort_at);
    logic fb [NB];
    int   n;
    n = 0;
    for (int b = 0; b < NB; b++) begin
      if (b < START_BITS_DEF) fb[b] = START_LEVEL_DEF;
      else if (b < START_BITS_DEF + DATA_BITS_DEF) fb[b] = d[b - START_BITS_DEF];
      else fb[b] = stop_bad[b - START_BITS_DEF - DATA_BITS_DEF] ? ~STOP_LEVEL_DEF : STOP_LEVEL_DEF;
    end
    if (!en_phase) tick();
    start_edge = nedge;
    for (int b = 0; b < NB; b++) begin
      for (int s = 0; s < osr; s++) begin
        if (n == abort_at) begin
          rst_n = 1'b0;
          drive(1'b1);
          #1;
          return;
        end
        drive(fb[b]);
        tick();
        tick();
        n++;
      end
    end
    drive(1'b1);
  endtask

  task automatic model_frame(input logic [7:0] d, input logic [1:0] stop_bad);
    if (!m_valid) begin
      m_valid = 1'b1;
      m_data  = d;
      m_ferr  = |stop_bad;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic check_model(input string tag);
    check_eq({tag, ".valid"}, 32'(if16.o_valid), 32'(m_valid));
    check_eq({tag, ".ovr"}, 32'(if16.o_overrun), 32'(m_ovr));
    if (m_valid) begin
      check_eq({tag, ".data"}, 32'(if16.o_data), 32'(m_data));
      check_eq({tag, ".ferr"}, 32'(if16.o_frame_err), 32'(m_ferr));
    end
  endtask

  task automatic consume(input string tag);
    if16.i_ready = 1'b1;
    tick();
    if16.i_ready = 1'b0;
    m_valid = 1'b0;
    check_eq({tag, ".drop"}, 32'(if16.o_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] rd;
    logic [1:0] rs;
    if16.i_ready = 1'b0;
    if12.i_ready = 1'b0;
    #23;
    check_eq("rst.state", 32'(st16), 32'(ST_REARM));
    check_eq("rst.valid", 32'(if16.o_valid), 32'd0);
    check_eq("rst.data", 32'(if16.o_data), 32'd0);
    check_eq("rst.ovr", 32'(if16.o_overrun), 32'd0);
    rst_n = 1'b1;
    hold_idle(4);
    check_eq("rearm.idle", 32'(st16), 32'(ST_IDLE));

    // frame cycle k is sampled on edge start_edge+3+2k (2-clock sync, 1/0 enable)
    rise_edge = -1;
    send_frame(8'hA5, 2'b00, 16, -1);
    hold_idle(4);
    model_frame(8'hA5, 2'b00);
    check_model("a5");
    check_eq("a5.latency", 32'(rise_edge - start_edge), 32'(3 + 2 * (NB * 16 - 1)));
    consume("a5");
    hold_idle(2);

    drive(1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      tick();
    end
    check_eq("glitch.start", 32'(st16), 32'(ST_START));
    hold_idle(20);
    check_eq("glitch.idle", 32'(st16), 32'(ST_IDLE));
    check_eq("glitch.valid", 32'(if16.o_valid), 32'd0);

    send_frame(8'h3C, 2'b10, 16, -1);
    hold_idle(4);
    model_frame(8'h3C, 2'b10);
    check_model("3c");
    consume("3c");
    hold_idle(2);

    send_frame(8'h11, 2'b00, 16, -1);
    hold_idle(2);
    model_frame(8'h11, 2'b00);
    check_model("b2b1");
    send_frame(8'h22, 2'b00, 16, -1);
    hold_idle(4);
    model_frame(8'h22, 2'b00);
    check_model("b2b2");
    check_eq("b2b.ovr", 32'(if16.o_overrun), 32'd1);
    consume("b2b");
    hold_idle(2);

    for (int f = 0; f < 10; f++) begin
      rd = 8'($urandom);
      rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      send_frame(rd, rs, 16, -1);
      hold_idle(4);
      model_frame(rd, rs);
      check_model("rnd");
      if ($urandom_range(0, 1) == 1) consume("rnd");
      hold_idle(1);
    end

    use12 = 1'b1;
    send_frame(8'h5A, 2'b00, 12, -1);
    hold_idle(4);
    use12 = 1'b0;
    check_eq("osr12.valid", 32'(if12.o_valid), 32'd1);
    check_eq("osr12.data", 32'(if12.o_data), 32'h5A);
    check_eq("osr12.ferr", 32'(if12.o_frame_err), 32'd0);
    check_eq("osr12.ovr", 32'(if12.o_overrun), 32'd0);

    if (!m_valid) begin
      send_frame(8'h77, 2'b00, 16, -1);
      hold_idle(4);
      model_frame(8'h77, 2'b00);
    end
    check_model("prerst");
    send_frame(8'hFF, 2'b00, 16, 81);
    check_eq("midrst.state", 32'(st16), 32'(ST_REARM));
    check_eq("midrst.valid", 32'(if16.o_valid), 32'd0);
    check_eq("midrst.data", 32'(if16.o_data), 32'd0);
    check_eq("midrst.ferr", 32'(if16.o_frame_err), 32'd0);
    check_eq("midrst.ovr", 32'(if16.o_overrun), 32'd0);
    check_eq("midrst.st12", 32'(st12), 32'(ST_REARM));
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
    m_data  = 8'h00;
    tick();
    rst_n = 1'b1;
    hold_idle(4);
    send_frame(8'h01, 2'b00, 16, -1);
    hold_idle(4);
    model_frame(8'h01, 2'b00);
    check_model("post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
